// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and width constant for the handshaked multiplier
package mult_pkg;

    // Operand width used when the instantiating code does not override it.
    localparam int DEFAULT_W = 4;

    // Controller states: wait for operands, evaluate product, present product.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } mult_state_t;

    // Product width for a given operand width; (2^w-1)^2 always fits in 2*w bits.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/array_mult_structural.sv
// rtl/array_mult_structural.sv - combinational unsigned array multiplier built from AND gates and full-adder rows
import mult_pkg::*;

module array_mult_structural #(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    localparam int PW = prod_width(W);

    logic [PW-1:0] acc;
    logic [PW-1:0] row_sum;
    logic [PW-1:0] pp;
    logic          carry;

    // Each multiplier bit gates a shifted copy of the multiplicand, which is
    // folded into the running sum by a ripple row of full-adder cells.
    always_comb begin
        acc     = '0;
        row_sum = '0;
        pp      = '0;
        carry   = 1'b0;
        for (int i = 0; i < W; i++) begin
            pp    = {{W{1'b0}}, a & {W{b[i]}}} << i;
            carry = 1'b0;
            for (int j = 0; j < PW; j++) begin
                row_sum[j] = acc[j] ^ pp[j] ^ carry;
                carry      = (acc[j] & pp[j]) | (carry & (acc[j] ^ pp[j]));
            end
            // The carry out of the top cell is always zero: the product fits.
            acc = row_sum;
        end
        p = acc;
    end

endmodule

// File: rtl/mult_handshake_ctrl.sv
// rtl/mult_handshake_ctrl.sv - valid/ready wrapped multiplier with a three-state controller and handshake counter
import mult_pkg::*;

module mult_handshake_ctrl #(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_m,
    input  logic [W-1:0]   in_q,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p,
    output logic [7:0]     done_cnt
);

    mult_state_t    state;
    logic [W-1:0]   m_reg;
    logic [W-1:0]   q_reg;
    logic [2*W-1:0] product;

    // The multiplier only ever sees the captured operands, so upstream
    // activity outside IDLE cannot disturb an evaluation in progress.
    array_mult_structural #(
        .W (W)
    ) u_mult (
        .a (m_reg),
        .b (q_reg),
        .p (product)
    );

    // Controller: handshake flags are registered next to the state so that
    // in_ready and out_valid never depend combinationally on their partners.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            m_reg     <= '0;
            q_reg     <= '0;
            out_p     <= '0;
            done_cnt  <= 8'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        m_reg    <= in_m;
                        q_reg    <= in_q;
                        in_ready <= 1'b0;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    out_p     <= product;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    // out_p is only written in EVAL, so it holds while stalled.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        done_cnt  <= done_cnt + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_handshake_ctrl.md
MULT_HANDSHAKE_CTRL -- requirements
Module: mult_handshake_ctrl

Interface
REQ-001 SHALL have parameter W, default 4, meaning operand width in bits; product width is 2*W.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 SHALL have port in_m, input, W bits: multiplicand.
REQ-007 SHALL have port in_q, input, W bits: multiplier.
REQ-008 SHALL have port out_valid, output, 1 bit: out_p holds a valid product.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out_p.
REQ-010 SHALL have port out_p, output, 2*W bits: registered unsigned product.
REQ-011 SHALL have port done_cnt, output, 8 bits: count of completed output handshakes.

Function
REQ-012 SHALL implement an FSM with states IDLE, EVAL and OUT.
REQ-013 SHALL drive in_ready=1 only in IDLE.
REQ-014 SHALL, in IDLE on in_valid&&in_ready, register in_m/in_q into internal operand registers and enter EVAL.
REQ-015 SHALL, in EVAL, feed the operand registers to the combinational multiplier, capture its product into out_p at the clock edge, and enter OUT.
REQ-016 SHALL drive out_valid=1 only in OUT; out_p SHALL stay stable while out_valid=1 and out_ready=0.
REQ-017 SHALL, in OUT on out_ready=1, return to IDLE and increment done_cnt.
REQ-018 SHALL give fixed latency: operands accepted at edge N; out_valid high in the cycle after edge N+1.
REQ-019 SHALL give throughput of one product per 3 cycles when out_ready is held high, with no bubble beyond the FSM cycle.
REQ-020 SHALL ignore in_m/in_q/in_valid outside IDLE, with no effect on the operand registers.
REQ-021 SHALL compute products as unsigned with no truncation: max(2^W-1)^2 fits in 2*W bits.
REQ-022 SHALL wrap done_cnt modulo 256 (255 -> 0), with no saturation or flag.
REQ-023 SHALL leave state unchanged when out_ready=1 outside OUT.
REQ-024 SHALL contain no combinational path from in_valid to in_ready, or from out_ready to out_valid.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set state=IDLE, operand registers=0, out_p=0 and done_cnt=0, overriding any concurrent handshake.
REQ-026 SHALL hold in_ready=1 and out_valid=0 in the first cycle after reset deasserts.
REQ-027 SHALL, on reset during EVAL or OUT, discard the in-flight product with no output handshake and no count increment.

Structure
REQ-028 SHALL take the state-encoding typedef (IDLE/EVAL/OUT, 2 bits) and the default width constant from shared package mult_pkg.
REQ-029 SHALL instantiate array_mult_structural as its one sub-module for the multiply; no other arithmetic instance is allowed.
REQ-030 SHALL be synthesizable in 120-400 lines of RTL with no latches.

Verification
REQ-031 SHALL verify: rst high 2 cycles -> in_ready=1, out_valid=0, out_p=0x00, done_cnt=0.
REQ-032 SHALL verify: m=0xF, q=0xF with out_ready=1 -> out_p=0xE1 with out_valid exactly 2 cycles after the accept edge, done_cnt=1.
REQ-033 SHALL verify: m=0x9, q=0x5 with out_ready=0 for 5 cycles -> out_p=0x2D stable and in_ready=0 throughout; on release, handshake completes and in_ready=1 next cycle.
REQ-034 SHALL verify: in_valid held high with new operands (m=0x2, q=0x8) while in OUT -> ignored; the next accept occurs only in IDLE and yields 0x10.
REQ-035 SHALL verify: rst asserted in EVAL for m=0x8, q=0x8 -> no out_valid pulse, done_cnt unchanged at 0, out_p=0x00.
REQ-036 SHALL verify: 256 back-to-back transactions with random operands against a reference model -> all products match and done_cnt wraps to 0.
